// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready
// result port. Most operations take one cycle in CALC. MUL (shift-add) and
// DIV (restoring) with a non-zero divisor iterate one bit per cycle.
// Carry-in for ADC/SBB/RCL/RCR comes from the internal carry register cf_q.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic [5:0]       Status,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. A producer
    // holds its valid and data stable until the transfer; in_ready may depend
    // combinationally on out_ready so a retiring result frees the block at once.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       f_q, f_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;
    logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [5:0]       st_q, st_d;
    logic             cf_q, cf_d;

    logic             accept;
    logic             is_multi;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;

    logic [WIDTH-1:0] alu_res, alu_hi;
    logic             alu_c, alu_v, alu_ac;
    logic [WIDTH-1:0] sel_res, sel_hi;
    logic             sel_c, sel_v, sel_ac;
    logic [5:0]       sel_st;

    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign Result      = res_q;
    assign Hi          = hi_q;
    assign Status      = st_q;
    assign dbg_state_o = state_q;

    // MUL/DIV with a zero second operand finish in one cycle like every other op.
    assign is_multi = ((f_q == OP_MUL) || (f_q == OP_DIV)) && (b_q != '0);

    // INC/DEC reuse the add/sub datapath with an implicit operand of one.
    assign op_b  = ((f_q == OP_INC) || (f_q == OP_DEC)) ? ONE_W : b_q;
    assign cin   = ((f_q == OP_ADC) || (f_q == OP_SBB)) ? cf_q : 1'b0;
    assign sum_w = {1'b0, a_q} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    assign dif_w = {1'b0, a_q} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};

    // One shift-add step: conditionally add the multiplicand, then shift the
    // {hi, lo} pair right so the multiplier drains out of lo as the product fills in.
    assign mul_sum = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    // One restoring-divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. The remainder is always below the
    // divisor, so the W-bit difference is exact.
    assign div_shift = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, b_q});

    // Single-cycle result and raw flags from the captured operands.
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ac  = 1'b0;
        case (f_q)
            OP_INC, OP_ADD, OP_ADC: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == op_b[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
                alu_ac  = a_q[4] ^ op_b[4] ^ sum_w[4];
            end
            OP_DEC, OP_SUB, OP_SBB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] != op_b[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
                alu_ac  = (a_q[3:0] < op_b[3:0]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_MUL: alu_res = '0;
            OP_DIV: begin
                alu_res = '1;
                alu_hi  = a_q;
                alu_v   = 1'b1;
            end
            OP_SHL, OP_SAL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_SAR: begin
                alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_ROL: begin
                alu_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
                alu_c   = a_q[WIDTH-1];
            end
            OP_ROR: begin
                alu_res = {a_q[0], a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_RCL: begin
                alu_res = {a_q[WIDTH-2:0], cf_q};
                alu_c   = a_q[WIDTH-1];
            end
            OP_RCR: begin
                alu_res = {cf_q, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: alu_res = '0;
        endcase
    end

    // Pick the iterative or single-cycle result and build the status word.
    always_comb begin
        sel_res = alu_res;
        sel_hi  = alu_hi;
        sel_c   = alu_c;
        sel_v   = alu_v;
        sel_ac  = alu_ac;
        if (is_multi) begin
            sel_res = wrk_lo_q;
            sel_hi  = wrk_hi_q;
            sel_c   = (f_q == OP_MUL) && (wrk_hi_q != '0);
            sel_v   = (f_q == OP_MUL) && (wrk_hi_q != '0);
            sel_ac  = 1'b0;
        end
        sel_st = {sel_c, (sel_res == '0), sel_res[WIDTH-1], sel_v, ~^sel_res, sel_ac};
    end

    // Next-state, operand capture, iteration and result load.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        f_d      = f_q;
        cnt_d    = cnt_q;
        wrk_hi_d = wrk_hi_q;
        wrk_lo_d = wrk_lo_q;
        res_d    = res_q;
        hi_d     = hi_q;
        st_d     = st_q;
        cf_d     = cf_q;
        case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                if (is_multi && (cnt_q != ITERS)) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (f_q == OP_MUL) begin
                        wrk_hi_d = mul_sum[WIDTH:1];
                        wrk_lo_d = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
                    end else begin
                        wrk_hi_d = div_fits ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
                        wrk_lo_d = {wrk_lo_q[WIDTH-2:0], div_fits};
                    end
                end else begin
                    res_d   = sel_res;
                    hi_d    = sel_hi;
                    st_d    = sel_st;
                    cf_d    = sel_st[5];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request may arrive in IDLE or in the same cycle DONE retires.
        if (accept) begin
            state_d  = CALC;
            a_d      = A;
            b_d      = B;
            f_d      = F;
            cnt_d    = '0;
            wrk_hi_d = '0;
            wrk_lo_d = (F == OP_MUL) ? B : A;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            cnt_q    <= '0;
            wrk_hi_q <= '0;
            wrk_lo_q <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            st_q     <= '0;
            cf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            wrk_hi_q <= wrk_hi_d;
            wrk_lo_q <= wrk_lo_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            st_q     <= st_d;
            cf_q     <= cf_d;
        end
    end

endmodule
